countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 128 ++++++++++++
 tb/tb_countdown_timer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaled tick, pause/resume and optional auto-reload.
// Raises a one-cycle done pulse on every terminal count and exposes its FSM state for checkers.
module countdown_timer #(
  parameter int N        = 4,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         start,
  input  logic         pause,
  input  logic         auto_reload,
  output logic [N-1:0] count,
  output logic         running,
  output logic         expired,
  output logic         done,
  output logic [1:0]   state_dbg
);

  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   count_q, count_d;
  logic [N-1:0]   reload_q, reload_d;
  logic [PW-1:0]  pre_q, pre_d;
  logic           done_q, done_d;
  logic           tick;

  // Control inputs are level-sampled every cycle; there is no handshake, a high
  // level on a rising edge is one request and priority is load > start/pause > tick.
  assign tick = (state_q == RUN) && (pre_q == PRE_LAST) && !pause && !load;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    pre_d    = pre_q;
    done_d   = 1'b0;
    if (load) begin
      reload_d = load_val;
      count_d  = load_val;
      pre_d    = '0;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE, EXPIRED: begin
          if (start) begin
            if (reload_q != '0) begin
              count_d = reload_q;
              pre_d   = '0;
              state_d = RUN;
            end else begin
              // Zero-length run terminates immediately; auto_reload cannot apply.
              count_d = '0;
              state_d = EXPIRED;
              done_d  = 1'b1;
            end
          end
        end
        PAUSED: begin
          if (start) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
            if (tick) begin
              if (count_q > N'(1)) begin
                count_d = count_q - N'(1);
              end else if (auto_reload) begin
                count_d = reload_q;
                done_d  = 1'b1;
              end else begin
                count_d = '0;
                state_d = EXPIRED;
                done_d  = 1'b1;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q  <= '0;
      reload_q <= '0;
      pre_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      pre_q    <= pre_d;
      done_q   <= done_d;
    end
  end

  assign count     = count_q;
  assign done      = done_q;
  assign running   = (state_q == RUN);
  assign expired   = (state_q == EXPIRED);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer (N = 4, PRESCALE = 2): reset, expiry, auto-reload,
// pause/resume, load override, zero load and asynchronous reset mid-run.
module tb_countdown_timer;

  localparam int N        = 4;
  localparam int PRESCALE = 2;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PAUSED  = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  logic         clk = 1'b0;
  logic         nrst;
  logic         load;
  logic [N-1:0] load_val;
  logic         start;
  logic         pause;
  logic         auto_reload;
  logic [N-1:0] count;
  logic         running;
  logic         expired;
  logic         done;
  logic [1:0]   state_dbg;

  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] e;

  countdown_timer #(.N(N), .PRESCALE(PRESCALE)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .pause       (pause),
    .auto_reload (auto_reload),
    .count       (count),
    .running     (running),
    .expired     (expired),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard compare
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic [N-1:0] cnt,
                         input logic dn);
    chk({tag, ".state"},   32'(state_dbg), 32'(st));
    chk({tag, ".count"},   32'(count),     32'(cnt));
    chk({tag, ".done"},    32'(done),      32'(dn));
    chk({tag, ".running"}, 32'(running),   32'(st == S_RUN));
    chk({tag, ".expired"}, 32'(expired),   32'(st == S_EXPIRED));
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge, outputs sampled there too
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [N-1:0] v);
    load_val = v;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0; auto_reload = 1'b0;
    #1;
    chk_all("reset", S_IDLE, 4'd0, 1'b0);
    step();
    nrst = 1'b1;
    step();
    chk_all("reset_released", S_IDLE, 4'd0, 1'b0);

    // start with reload register still zero: immediate expiry
    do_start();
    chk_all("start_zero", S_EXPIRED, 4'd0, 1'b1);
    step();
    chk_all("start_zero_after", S_EXPIRED, 4'd0, 1'b0);

    // load 5, one-shot run; a start while running must not disturb the prescaler
    do_load(4'd5);
    chk_all("r031.load", S_IDLE, 4'd5, 1'b0);
    do_start();
    chk_all("r031.entry", S_RUN, 4'd5, 1'b0);
    for (int k = 1; k <= 10; k++) exp_q.push_back(4'(5 - k / 2));
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) start = 1'b1;
      step();
      start = 1'b0;
      e = exp_q.pop_front();
      chk($sformatf("r031.count_k%0d", k), 32'(count), 32'(e));
      chk($sformatf("r031.done_k%0d", k),  32'(done),  32'(k == 10));
    end
    chk_all("r031.end", S_EXPIRED, 4'd0, 1'b1);
    step();
    step();
    chk_all("r031.hold", S_EXPIRED, 4'd0, 1'b0);

    // load 3 with auto-reload, then drop auto_reload to let it expire
    auto_reload = 1'b1;
    do_load(4'd3);
    do_start();
    chk_all("r032.entry", S_RUN, 4'd3, 1'b0);
    for (int k = 1; k <= 18; k++) exp_q.push_back(4'(3 - ((k / 2) % 3)));
    for (int k = 1; k <= 18; k++) begin
      step();
      e = exp_q.pop_front();
      chk($sformatf("r032.count_k%0d", k),   32'(count),   32'(e));
      chk($sformatf("r032.done_k%0d", k),    32'(done),    32'(k % 6 == 0));
      chk($sformatf("r032.running_k%0d", k), 32'(running), 32'd1);
    end
    auto_reload = 1'b0;
    for (int k = 19; k <= 24; k++) exp_q.push_back(4'(3 - (k - 18) / 2));
    for (int k = 19; k <= 24; k++) begin
      step();
      e = exp_q.pop_front();
      chk($sformatf("r032b.count_k%0d", k), 32'(count), 32'(e));
      chk($sformatf("r032b.done_k%0d", k),  32'(done),  32'(k == 24));
    end
    chk_all("r032b.end", S_EXPIRED, 4'd0, 1'b1);

    // pause ignored outside RUN
    pause = 1'b1;
    step();
    pause = 1'b0;
    chk_all("pause_in_expired", S_EXPIRED, 4'd0, 1'b0);

    // load 6, pause with prescaler mid-period; 7 cycles lost, done at E19 instead of E12
    do_load(4'd6);
    do_start();
    repeat (5) step();
    chk_all("r033.before_pause", S_RUN, 4'd4, 1'b0);
    pause = 1'b1;
    step();
    pause = 1'b0;
    chk_all("r033.paused", S_PAUSED, 4'd4, 1'b0);
    for (int k = 7; k <= 11; k++) begin
      step();
      chk_all($sformatf("r033.hold_k%0d", k), S_PAUSED, 4'd4, 1'b0);
    end
    do_start();
    chk_all("r033.resume", S_RUN, 4'd4, 1'b0);
    step();
    chk_all("r033.first_tick", S_RUN, 4'd3, 1'b0);
    for (int k = 14; k <= 19; k++) begin
      step();
      chk($sformatf("r033.done_k%0d", k), 32'(done), 32'(k == 19));
    end
    chk_all("r033.end", S_EXPIRED, 4'd0, 1'b1);

    // load during RUN on a cycle that would otherwise tick
    do_load(4'd5);
    do_start();
    repeat (7) step();
    chk_all("r034.before", S_RUN, 4'd2, 1'b0);
    do_load(4'd9);
    chk_all("r034.load", S_IDLE, 4'd9, 1'b0);
    step();
    step();
    chk_all("r034.after", S_IDLE, 4'd9, 1'b0);

    // load 0 then start
    do_load(4'd0);
    do_start();
    chk_all("r035.start", S_EXPIRED, 4'd0, 1'b1);
    step();
    chk_all("r035.after", S_EXPIRED, 4'd0, 1'b0);

    // asynchronous reset mid-run, observed before the next clock edge
    do_load(4'd5);
    do_start();
    repeat (4) step();
    chk_all("r036.before", S_RUN, 4'd3, 1'b0);
    #3;
    nrst = 1'b0;
    #1;
    chk_all("r036.async", S_IDLE, 4'd0, 1'b0);
    step();
    nrst = 1'b1;
    step();
    chk_all("r036.released", S_IDLE, 4'd0, 1'b0);
    do_start();
    chk_all("r030.restart", S_EXPIRED, 4'd0, 1'b1);
    step();
    chk_all("r030.after", S_EXPIRED, 4'd0, 1'b0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
